// File: rtl/wb_arbiter.sv
// Write-back port arbiter: W-stage writes always take the register-file port,
// long-latency results queue in a 2-entry FIFO and drain into free port cycles.
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    input  logic        IssueValid,
    input  logic [4:0]  IssueRd,
    input  logic        LuValid,
    input  logic [4:0]  LuRd,
    input  logic [31:0] LuData,
    output logic        LuReady,
    output logic        RegWriteRF,
    output logic [4:0]  RdRF,
    output logic [31:0] WDRF,
    output logic [31:0] BusyVec,
    output logic        StallReq
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [4:0]  rdMem   [2];
    logic [31:0] dataMem [2];
    logic        wrPtrReg;
    logic        rdPtrReg;
    logic [1:0]  countReg;
    logic [1:0]  countNext;
    logic [31:0] busyReg;
    logic [31:0] busyNext;
    logic [3:0]  starveReg;
    logic [3:0]  starveNext;

    logic        pipeWrite;
    logic        fifoEmpty;
    logic        push;
    logic        pop;
    logic [4:0]  headRd;
    logic [31:0] headData;

    // A W-stage write to x0 is a free port cycle for the FIFO.
    assign pipeWrite = RegWriteW && (RdW != 5'd0);
    assign fifoEmpty = (countReg == 2'd0);
    assign LuReady   = (countReg < 2'd2);
    assign push      = LuValid && LuReady && (LuRd != 5'd0);
    assign pop       = !pipeWrite && !fifoEmpty;
    assign headRd    = rdMem[rdPtrReg];
    assign headData  = dataMem[rdPtrReg];

    always_comb begin
        RegWriteRF = 1'b0;
        RdRF       = 5'd0;
        WDRF       = 32'd0;
        if (pipeWrite) begin
            RegWriteRF = 1'b1;
            RdRF       = RdW;
            WDRF       = ResultW;
        end else if (!fifoEmpty) begin
            RegWriteRF = 1'b1;
            RdRF       = headRd;
            WDRF       = headData;
        end
    end

    always_comb begin
        countNext = countReg;
        case ({push, pop})
            2'b10:   countNext = countReg + 2'd1;
            2'b01:   countNext = countReg - 2'd1;
            default: countNext = countReg;
        endcase
    end

    // Issue sets and pop clears; a same-cycle set on the popped rd wins.
    assign busyNext[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : gBusy
            assign busyNext[gi] = (IssueValid && (IssueRd == 5'(gi)))
                               || (busyReg[gi] && !(pop && (headRd == 5'(gi))));
        end
    endgenerate

    always_comb begin
        starveNext = starveReg;
        if (fifoEmpty || pop)
            starveNext = 4'd0;
        else if (starveReg != LIMIT)
            starveNext = starveReg + 4'd1;
    end

    assign StallReq = (starveReg == LIMIT);
    assign BusyVec  = busyReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrReg  <= 1'b0;
            rdPtrReg  <= 1'b0;
            countReg  <= 2'd0;
            busyReg   <= 32'd0;
            starveReg <= 4'd0;
        end else begin
            wrPtrReg  <= wrPtrReg ^ push;
            rdPtrReg  <= rdPtrReg ^ pop;
            countReg  <= countNext;
            busyReg   <= busyNext;
            starveReg <= starveNext;
        end
    end

    // Storage needs no reset: the occupancy count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            rdMem[wrPtrReg]   <= LuRd;
            dataMem[wrPtrReg] <= LuData;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model of the write port.
module tb_wb_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = '0;
    logic [31:0] ResultW = '0;
    logic        IssueValid = 1'b0;
    logic [4:0]  IssueRd = '0;
    logic        LuValid = 1'b0;
    logic [4:0]  LuRd = '0;
    logic [31:0] LuData = '0;
    logic        LuReady;
    logic        RegWriteRF;
    logic [4:0]  RdRF;
    logic [31:0] WDRF;
    logic [31:0] BusyVec;
    logic        StallReq;

    always #5 clk = ~clk;

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .IssueValid(IssueValid), .IssueRd(IssueRd),
        .LuValid(LuValid), .LuRd(LuRd), .LuData(LuData),
        .LuReady(LuReady), .RegWriteRF(RegWriteRF), .RdRF(RdRF), .WDRF(WDRF),
        .BusyVec(BusyVec), .StallReq(StallReq)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mBusy = '0;
    int          mStarve = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic idleInputs();
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        IssueValid = 1'b0; IssueRd = '0;
        LuValid = 1'b0; LuRd = '0; LuData = '0;
    endtask

    // One rising edge; the model advances by the port/FIFO/scoreboard rules.
    task automatic tick();
        bit     pw, popped, pushed;
        int     sizeBefore;
        entry_t e;
        pw         = RegWriteW && (RdW != 5'd0);
        sizeBefore = mq.size();
        popped     = !pw && (sizeBefore > 0);
        pushed     = LuValid && (sizeBefore < 2) && (LuRd != 5'd0);
        if (pw)
            $display("[%0t] RF write x%0d = %h (pipeline)", $time, RdW, ResultW);
        else if (popped)
            $display("[%0t] RF write x%0d = %h (fifo)", $time, mq[0].rd, mq[0].data);
        @(posedge clk);
        if (popped) begin
            mBusy[mq[0].rd] = 1'b0;
            void'(mq.pop_front());
        end
        if (pushed) begin
            e.rd = LuRd; e.data = LuData;
            mq.push_back(e);
        end
        if (IssueValid && IssueRd != 5'd0) mBusy[IssueRd] = 1'b1;
        if (sizeBefore == 0 || popped) mStarve = 0;
        else if (mStarve < LIMIT) mStarve++;
        #2;
    endtask

    task automatic applyReset();
        idleInputs();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mq.delete();
        mBusy = '0;
        mStarve = 0;
    endtask

    task automatic test_reset();
        idleInputs();
        #2;
        checks++;
        if ({LuReady, BusyVec, StallReq, RegWriteRF} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: got ready=%b busy=%h stall=%b wr=%b want 1/0/0/0",
                     LuReady, BusyVec, StallReq, RegWriteRF);
        end
        RegWriteW = 1'b1; RdW = 5'd6; ResultW = 32'h1234;
        #1;
        checks++;
        if ({RegWriteRF, RdRF, WDRF} !== {1'b1, 5'd6, 32'h1234}) begin
            errors++;
            $display("FAIL reset_passthru: got %b/%0d/%h want 1/6/00001234", RegWriteRF, RdRF, WDRF);
        end
        applyReset();
        #1;
        checks++;
        if ({LuReady, BusyVec, StallReq, RegWriteRF} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%h stall=%b wr=%b want 1/0/0/0",
                     LuReady, BusyVec, StallReq, RegWriteRF);
        end
    endtask

    task automatic test_priority();
        applyReset();
        IssueValid = 1'b1; IssueRd = 5'd7;
        LuValid = 1'b1; LuRd = 5'd7; LuData = 32'h11;
        #1;
        checks++;
        if (RegWriteRF !== 1'b0) begin
            errors++;
            $display("FAIL prio_no_bypass: got wr=%b want 0", RegWriteRF);
        end
        tick();
        idleInputs();
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hA5A5A5A5;
        #1;
        checks++;
        if ({RegWriteRF, RdRF, WDRF} !== {1'b1, 5'd5, 32'hA5A5A5A5}) begin
            errors++;
            $display("FAIL prio_pipe_wins: got %b/%0d/%h want 1/5/a5a5a5a5", RegWriteRF, RdRF, WDRF);
        end
        tick();
        idleInputs();
        #1;
        checks++;
        if ({RegWriteRF, RdRF, WDRF, BusyVec[7]} !== {1'b1, 5'd7, 32'h11, 1'b1}) begin
            errors++;
            $display("FAIL prio_drain: got %b/%0d/%h busy7=%b want 1/7/00000011/1",
                     RegWriteRF, RdRF, WDRF, BusyVec[7]);
        end
        tick();
        checks++;
        if ({RegWriteRF, BusyVec} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL prio_after: got wr=%b busy=%h want 0/0", RegWriteRF, BusyVec);
        end
    endtask

    task automatic test_scoreboard();
        applyReset();
        IssueValid = 1'b1; IssueRd = 5'd9;
        tick();
        idleInputs();
        #1;
        checks++;
        if (BusyVec !== 32'h0000_0200) begin
            errors++;
            $display("FAIL sb_set: got busy=%h want 00000200", BusyVec);
        end
        LuValid = 1'b1; LuRd = 5'd9; LuData = 32'hDEAD;
        tick();
        idleInputs();
        #1;
        checks++;
        if ({RegWriteRF, RdRF, WDRF, BusyVec} !== {1'b1, 5'd9, 32'hDEAD, 32'h200}) begin
            errors++;
            $display("FAIL sb_write: got %b/%0d/%h busy=%h want 1/9/0000dead/00000200",
                     RegWriteRF, RdRF, WDRF, BusyVec);
        end
        tick();
        IssueValid = 1'b1; IssueRd = 5'd0;
        #1;
        checks++;
        if (BusyVec !== 32'd0) begin
            errors++;
            $display("FAIL sb_clear: got busy=%h want 0", BusyVec);
        end
        tick();
        checks++;
        if (BusyVec !== 32'd0) begin
            errors++;
            $display("FAIL sb_rd0: got busy=%h want 0", BusyVec);
        end
        // Re-issue to the rd that pops in the same cycle: the set must survive.
        IssueValid = 1'b1; IssueRd = 5'd12;
        LuValid = 1'b1; LuRd = 5'd12; LuData = 32'h55;
        tick();
        idleInputs();
        IssueValid = 1'b1; IssueRd = 5'd12;
        tick();
        idleInputs();
        #1;
        checks++;
        if (BusyVec !== 32'h0000_1000) begin
            errors++;
            $display("FAIL sb_set_wins: got busy=%h want 00001000", BusyVec);
        end
    endtask

    task automatic test_full();
        applyReset();
        RegWriteW = 1'b1; RdW = 5'd1; ResultW = $urandom;
        LuValid = 1'b1; LuRd = 5'd3; LuData = 32'd1;
        tick();
        LuRd = 5'd4; LuData = 32'd2;
        tick();
        LuRd = 5'd5; LuData = 32'd3;
        #1;
        checks++;
        if (LuReady !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b want 0", LuReady);
        end
        tick();
        RegWriteW = 1'b0;
        #1;
        checks++;
        if ({RegWriteRF, RdRF, WDRF} !== {1'b1, 5'd3, 32'd1}) begin
            errors++;
            $display("FAIL full_drain1: got %b/%0d/%h want 1/3/00000001", RegWriteRF, RdRF, WDRF);
        end
        tick();
        LuValid = 1'b0;
        #1;
        checks++;
        if ({RegWriteRF, RdRF, WDRF, LuReady} !== {1'b1, 5'd4, 32'd2, 1'b1}) begin
            errors++;
            $display("FAIL full_drain2: got %b/%0d/%h ready=%b want 1/4/00000002/1",
                     RegWriteRF, RdRF, WDRF, LuReady);
        end
        tick();
        checks++;
        if (RegWriteRF !== 1'b0) begin
            errors++;
            $display("FAIL full_dropped: got wr=%b want 0", RegWriteRF);
        end
    endtask

    task automatic test_starvation();
        applyReset();
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = $urandom;
        LuValid = 1'b1; LuRd = 5'd8; LuData = 32'h77;
        tick();
        LuValid = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            #1;
            checks++;
            if (StallReq !== 1'b0) begin
                errors++;
                $display("FAIL starve_early: cycle %0d got %b want 0", i, StallReq);
            end
            tick();
        end
        checks++;
        if (StallReq !== 1'b1) begin
            errors++;
            $display("FAIL starve_rise: got %b want 1", StallReq);
        end
        tick();
        checks++;
        if (StallReq !== 1'b1) begin
            errors++;
            $display("FAIL starve_hold: got %b want 1", StallReq);
        end
        RegWriteW = 1'b0;
        #1;
        checks++;
        if ({RegWriteRF, RdRF, WDRF} !== {1'b1, 5'd8, 32'h77}) begin
            errors++;
            $display("FAIL starve_bubble: got %b/%0d/%h want 1/8/00000077", RegWriteRF, RdRF, WDRF);
        end
        tick();
        checks++;
        if ({StallReq, RegWriteRF} !== 2'b00) begin
            errors++;
            $display("FAIL starve_fall: got stall=%b wr=%b want 0/0", StallReq, RegWriteRF);
        end
    endtask

    task automatic test_edge();
        applyReset();
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h3;
        IssueValid = 1'b1; IssueRd = 5'd10;
        LuValid = 1'b1; LuRd = 5'd10; LuData = 32'hA;
        tick();
        IssueValid = 1'b0;
        LuRd = 5'd0; LuData = 32'hB;
        tick();
        IssueValid = 1'b1; IssueRd = 5'd11;
        LuRd = 5'd11; LuData = 32'hC;
        #1;
        checks++;
        if (LuReady !== 1'b1) begin
            errors++;
            $display("FAIL edge_rd0_discard: got ready=%b want 1", LuReady);
        end
        tick();
        idleInputs();
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFF;
        #1;
        checks++;
        if ({LuReady, RegWriteRF, RdRF, WDRF} !== {1'b0, 1'b1, 5'd10, 32'hA}) begin
            errors++;
            $display("FAIL edge_rdw0_drain: got ready=%b %b/%0d/%h want 0/1/10/0000000a",
                     LuReady, RegWriteRF, RdRF, WDRF);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({LuReady, BusyVec, StallReq, RegWriteRF} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL edge_async_reset: got ready=%b busy=%h stall=%b wr=%b want 1/0/0/0",
                     LuReady, BusyVec, StallReq, RegWriteRF);
        end
        applyReset();
    endtask

    task automatic test_random();
        logic        expWr;
        logic [4:0]  expRd;
        logic [31:0] expData;
        logic [4:0]  r;
        applyReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            idleInputs();
            RegWriteW = ($urandom_range(0, 99) < 45) && (mStarve != LIMIT || $urandom_range(0, 3) == 0);
            r = 5'($urandom_range(0, 31));
            RdW = mBusy[r] ? 5'd0 : r;
            ResultW = $urandom;
            r = 5'($urandom_range(0, 31));
            IssueValid = ($urandom_range(0, 99) < 30) && !mBusy[r];
            IssueRd = r;
            LuValid = $urandom_range(0, 99) < 40;
            LuRd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            LuData = $urandom;
            #1;
            if (RegWriteW && RdW != 5'd0) begin
                expWr = 1'b1; expRd = RdW; expData = ResultW;
            end else if (mq.size() > 0) begin
                expWr = 1'b1; expRd = mq[0].rd; expData = mq[0].data;
            end else begin
                expWr = 1'b0; expRd = 5'd0; expData = 32'd0;
            end
            checks++;
            if ({RegWriteRF, RdRF, WDRF} !== {expWr, expRd, expData}) begin
                errors++;
                $display("FAIL rand_port: cycle %0d got %b/%0d/%h want %b/%0d/%h",
                         cyc, RegWriteRF, RdRF, WDRF, expWr, expRd, expData);
            end
            checks++;
            if ({LuReady, StallReq, BusyVec} !== {mq.size() < 2, mStarve == LIMIT, mBusy}) begin
                errors++;
                $display("FAIL rand_state: cycle %0d got ready=%b stall=%b busy=%h want %b/%b/%h",
                         cyc, LuReady, StallReq, BusyVec, mq.size() < 2, mStarve == LIMIT, mBusy);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_scoreboard();
        test_full();
        test_starvation();
        test_edge();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
